progress_bar_overlay: RTL and testbench
=======================================

# progress_bar_overlay

Parametrised countdown-bar overlay stage for the SkyHop VGA pipeline. It replaces the fixed time bar with a configurable-geometry bar that drains over `DURATION_MS` milliseconds. It supports pause and restart, and latches the bar length once per frame so the bar never tears. It sits after the start-screen stage, consumes the 1 ms tick, and forwards all timing signals with one cycle of latency.

## Interface
- `BAR_X`, 11'd16: left edge of the bar area, in pixels.
- `BAR_Y`, 11'd8: top edge of the bar area, in pixels.
- `BAR_W`, 11'd256: full bar length, in pixels; must be ≤ `DURATION_MS`.
- `BAR_H`, 11'd12: bar height, in pixels.
- `DURATION_MS`, 20'd30000: countdown length, in ms ticks.
- `FG_COLOR`, 12'hF80: colour of the filled region.
- `EMPTY_COLOR`, 12'h333: colour of the drained region.
- `BORDER_COLOR`, 12'hFFF: border colour; used only with `BAR_BORDER_EN`.
- `clk`  in  1  pixel clock (40 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `module_en`  in  1  1 = draw the bar; 0 = pass rgb through (counting continues).
- `one_ms_tick`  in  1  single-cycle 1 ms strobe.
- `start`  in  1  level input; a rising edge (re)starts the countdown.
- `pause`  in  1  level input; while high in RUN, ticks are ignored.
- `vcount_in`, `hcount_in`  in  11  pixel position.
- `vsync_in`, `hsync_in`, `vblnk_in`, `hblnk_in`  in  1  timing signals.
- `rgb_in`  in  12  upstream colour.
- `vcount_out`, `hcount_out`  out  11  `*_in` delayed by 1 cycle.
- `vsync_out`, `hsync_out`, `vblnk_out`, `hblnk_out`  out  1  `*_in` delayed by 1 cycle.
- `rgb_out`  out  12  composited colour.
- `elapsed`  out  1  high while the block is in ELAPSED.
- `remaining_ms`  out  20  milliseconds left in the countdown.

## Operation
- FSM states: IDLE, RUN, PAUSE, ELAPSED.
  - IDLE → RUN on a `start` rising edge.
  - RUN → PAUSE when `pause` is high.
  - PAUSE → RUN when `pause` is low.
  - RUN → ELAPSED when `remaining_ms` reaches 0.
  - Any state → RUN on a `start` rising edge; this reloads the countdown.
- `start` edge detection: `start` is registered, and a rising edge is `start & ~start_q`.
- On reload:
  - `remaining_ms` ← `DURATION_MS`.
  - `fill` ← `BAR_W`.
  - `acc` ← 0.
- On each tick in RUN:
  - `remaining_ms` decrements by 1.
  - `acc` ← `acc + BAR_W`.
  - If `acc + BAR_W ≥ DURATION_MS`, then `acc` ← `acc + BAR_W − DURATION_MS` and `fill` decrements by 1.
  - At most one pixel is removed per tick. `fill` reaches 0 on exactly the same tick that `remaining_ms` reaches 0.
- `acc` is 21 bits wide; the comparison is unsigned.
- Frame latch: `fill_frame` ← `fill` on the rising edge of `vblnk_in`. Drawing uses only `fill_frame`.
- Pixel selection, using registered inputs: a pixel is inside the bar when `BAR_X ≤ hcount < BAR_X+BAR_W` and `BAR_Y ≤ vcount < BAR_Y+BAR_H`.
  - Inside, with `hcount − BAR_X < fill_frame`: `FG_COLOR`.
  - Inside, otherwise: `EMPTY_COLOR`.
  - Outside the bar: `rgb_in`.
  - When `module_en`=0, `vblnk` or `hblnk` is high, or the state is IDLE: `rgb_in` is forwarded unchanged. During blanking this forwards blank.
- Boundary rules:
  - A `start` edge and a tick in the same cycle: the reload wins, and the tick is discarded.
  - A tick in ELAPSED, IDLE or PAUSE has no effect.
  - `pause` has no effect in IDLE or ELAPSED.
  - `remaining_ms` never underflows; it holds at 0 in ELAPSED.
  - Asserting `rst` mid-run forces the block immediately back to IDLE.

## Timing
- Pipeline latency is 1 clock for every `*_out` signal, including `rgb_out`.
- `elapsed` is asserted in the cycle after the tick that brings `remaining_ms` to 0.
- `fill` changes the cycle after a tick, but appears on screen only from the next frame.
- Reset values:
  - All timing outputs 0.
  - `rgb_out` 12'h000.
  - `elapsed` 0.
  - `remaining_ms` = `DURATION_MS`.
  - `fill` = `fill_frame` = `BAR_W`.
  - State IDLE.
  - `start_q` 0.

## Configuration
- `BAR_BORDER_EN` defined: a 1-pixel frame just outside the bar area (`BAR_X−1 … BAR_X+BAR_W`, `BAR_Y−1 … BAR_Y+BAR_H`) is drawn in `BORDER_COLOR` whenever the bar is drawn. The border requires `BAR_X`, `BAR_Y` ≥ 1.
- `BAR_BORDER_EN` not defined: no border logic is built, and pixels outside the bar pass `rgb_in`.

## Structure
- `skyhop_pkg` holds:
  - the FSM state enum `bar_state_t`;
  - the widths `VGA_CNT_W`=11 and `RGB_W`=12;
  - the default colour constants.
- Sub-module `bar_fill_counter` holds the FSM, `remaining_ms`, `acc` and `fill`.
- The top level holds the timing pipeline, the frame latch and the compositor.

## Test plan
- Use `DURATION_MS`=10 and `BAR_W`=4 throughout.
- Start, then 10 ticks → `fill` steps 4→3 at tick 3, 2 at tick 5, 1 at tick 8, 0 at tick 10; `elapsed` rises the cycle after tick 10.
- Start, 4 ticks, `pause` high for 5 ticks, low, 6 ticks → `remaining_ms` holds at 6 during the pause and reaches 0 only after the final tick.
- A `start` edge coincident with tick 7 → `remaining_ms`=10, `fill`=4, and that tick is not counted.
- `fill` changes mid-frame → `rgb_out` on the bar rows changes only after the next `vblnk_in` rising edge.
- `module_en`=0 with `rgb_in`=12'hABC → `rgb_out`=12'hABC one cycle later, and every timing output equals its input delayed by 1.
- Assert `rst` during RUN with `remaining_ms`=3 → state IDLE, `remaining_ms`=10, `elapsed`=0, `rgb_out`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/skyhop_pkg.sv
// Shared types and constants for the SkyHop VGA overlay stages.
// Holds the countdown-bar FSM state enum, the pixel/colour widths
// and the default bar colours.
package skyhop_pkg;

   localparam int VGA_CNT_W = 11;
   localparam int RGB_W     = 12;
   localparam int MS_W      = 20;
   localparam int ACC_W     = 21;

   localparam logic [RGB_W-1:0] FG_COLOR_DEF     = 12'hF80;
   localparam logic [RGB_W-1:0] EMPTY_COLOR_DEF  = 12'h333;
   localparam logic [RGB_W-1:0] BORDER_COLOR_DEF = 12'hFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      ELAPSED = 2'd3
   } bar_state_t;

endpackage

// File: rtl/bar_fill_counter.sv
// Countdown engine for the progress bar: owns the IDLE/RUN/PAUSE/ELAPSED
// state machine, the millisecond countdown and the pixel fill length.
// The fill length is derived with a Bresenham-style accumulator so that
// at most one pixel drains per tick and the bar empties on the very tick
// the countdown reaches zero.
module bar_fill_counter
   import skyhop_pkg::*;
#(
   parameter logic [VGA_CNT_W-1:0] BAR_W       = 11'd256,
   parameter logic [MS_W-1:0]      DURATION_MS = 20'd30000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 pause,
   input  logic                 one_ms_tick,
   output bar_state_t           state,
   output logic                 elapsed,
   output logic [MS_W-1:0]      remaining_ms,
   output logic [VGA_CNT_W-1:0] fill
);

   bar_state_t           state_q, state_d;
   logic                 start_q;
   logic                 elapsed_q, elapsed_d;
   logic [MS_W-1:0]      remaining_q, remaining_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [VGA_CNT_W-1:0] fill_q, fill_d;
   logic [ACC_W-1:0]     acc_sum;
   logic                 start_edge;

   // Next-state logic: a start edge reloads from any state and swallows a coincident tick.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      acc_d       = acc_q;
      fill_d      = fill_q;
      acc_sum     = acc_q + {{(ACC_W-VGA_CNT_W){1'b0}}, BAR_W};
      start_edge  = start & ~start_q;

      if (start_edge) begin
         state_d     = RUN;
         remaining_d = DURATION_MS;
         fill_d      = BAR_W;
         acc_d       = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (pause) begin
                  state_d = PAUSE;
               end else if (one_ms_tick) begin
                  if (remaining_q <= 20'd1) begin
                     remaining_d = '0;
                     state_d     = ELAPSED;
                  end else begin
                     remaining_d = remaining_q - 20'd1;
                  end
                  if (acc_sum >= {1'b0, DURATION_MS}) begin
                     acc_d = acc_sum - {1'b0, DURATION_MS};
                     if (fill_q != '0) begin
                        fill_d = fill_q - 11'd1;
                     end
                  end else begin
                     acc_d = acc_sum;
                  end
               end
            end
            PAUSE: begin
               if (!pause) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end

      elapsed_d = (state_d == ELAPSED);
   end

   // State, countdown and registered flags; reset returns straight to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         start_q     <= 1'b0;
         elapsed_q   <= 1'b0;
         remaining_q <= DURATION_MS;
         acc_q       <= '0;
         fill_q      <= BAR_W;
      end else begin
         state_q     <= state_d;
         start_q     <= start;
         elapsed_q   <= elapsed_d;
         remaining_q <= remaining_d;
         acc_q       <= acc_d;
         fill_q      <= fill_d;
      end
   end

   assign state        = state_q;
   assign elapsed      = elapsed_q;
   assign remaining_ms = remaining_q;
   assign fill         = fill_q;

endmodule

// File: rtl/progress_bar_overlay.sv
// Countdown-bar overlay stage for the SkyHop VGA pipeline.
// Delays all timing signals by one clock, latches the fill length once per
// frame on the rising edge of vblnk_in, and composites the bar over rgb_in.
// Optional feature: define BAR_BORDER_EN to draw a 1-pixel border around the bar.
module progress_bar_overlay
   import skyhop_pkg::*;
#(
   parameter logic [VGA_CNT_W-1:0] BAR_X        = 11'd16,
   parameter logic [VGA_CNT_W-1:0] BAR_Y        = 11'd8,
   parameter logic [VGA_CNT_W-1:0] BAR_W        = 11'd256,
   parameter logic [VGA_CNT_W-1:0] BAR_H        = 11'd12,
   parameter logic [MS_W-1:0]      DURATION_MS  = 20'd30000,
`ifdef BAR_BORDER_EN
   parameter logic [RGB_W-1:0]     BORDER_COLOR = BORDER_COLOR_DEF,
`endif
   parameter logic [RGB_W-1:0]     FG_COLOR     = FG_COLOR_DEF,
   parameter logic [RGB_W-1:0]     EMPTY_COLOR  = EMPTY_COLOR_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 module_en,
   input  logic                 one_ms_tick,
   input  logic                 start,
   input  logic                 pause,
   input  logic [VGA_CNT_W-1:0] vcount_in,
   input  logic [VGA_CNT_W-1:0] hcount_in,
   input  logic                 vsync_in,
   input  logic                 hsync_in,
   input  logic                 vblnk_in,
   input  logic                 hblnk_in,
   input  logic [RGB_W-1:0]     rgb_in,
   output logic [VGA_CNT_W-1:0] vcount_out,
   output logic [VGA_CNT_W-1:0] hcount_out,
   output logic                 vsync_out,
   output logic                 hsync_out,
   output logic                 vblnk_out,
   output logic                 hblnk_out,
   output logic [RGB_W-1:0]     rgb_out,
   output logic                 elapsed,
   output logic [MS_W-1:0]      remaining_ms
);

   bar_state_t           bar_state;
   logic [VGA_CNT_W-1:0] fill;

   logic [VGA_CNT_W-1:0] vcount_q, hcount_q;
   logic                 vsync_q, hsync_q, vblnk_q, hblnk_q;
   logic [RGB_W-1:0]     rgb_out_q, rgb_out_d;
   logic [VGA_CNT_W-1:0] fill_frame_q, fill_frame_d;

   logic [VGA_CNT_W:0]   h_ext, v_ext;
   logic [VGA_CNT_W:0]   bar_x_lo, bar_x_end, bar_y_lo, bar_y_end;
   logic [VGA_CNT_W-1:0] h_off;
   logic                 in_bar;
   logic                 draw_en;

   bar_fill_counter #(
      .BAR_W       (BAR_W),
      .DURATION_MS (DURATION_MS)
   ) u_counter (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .pause        (pause),
      .one_ms_tick  (one_ms_tick),
      .state        (bar_state),
      .elapsed      (elapsed),
      .remaining_ms (remaining_ms),
      .fill         (fill)
   );

   // Bar geometry uses one extra bit so BAR_X+BAR_W cannot wrap.
   assign h_ext     = {1'b0, hcount_in};
   assign v_ext     = {1'b0, vcount_in};
   assign bar_x_lo  = {1'b0, BAR_X};
   assign bar_y_lo  = {1'b0, BAR_Y};
   assign bar_x_end = {1'b0, BAR_X} + {1'b0, BAR_W};
   assign bar_y_end = {1'b0, BAR_Y} + {1'b0, BAR_H};
   assign h_off     = hcount_in - BAR_X;
   assign in_bar    = (h_ext >= bar_x_lo) && (h_ext < bar_x_end) &&
                      (v_ext >= bar_y_lo) && (v_ext < bar_y_end);
   assign draw_en   = module_en && !vblnk_in && !hblnk_in && (bar_state != IDLE);

`ifdef BAR_BORDER_EN
   logic in_border;
   assign in_border = (h_ext >= bar_x_lo - 12'd1) && (h_ext <= bar_x_end) &&
                      (v_ext >= bar_y_lo - 12'd1) && (v_ext <= bar_y_end);
`endif

   // Compositor and frame latch: pick the pixel colour and capture fill once per frame.
   always_comb begin
      rgb_out_d    = rgb_in;
      fill_frame_d = fill_frame_q;

      if (vblnk_in && !vblnk_q) begin
         fill_frame_d = fill;
      end

      if (draw_en) begin
         if (in_bar) begin
            rgb_out_d = (h_off < fill_frame_q) ? FG_COLOR : EMPTY_COLOR;
         end
`ifdef BAR_BORDER_EN
         else if (in_border) begin
            rgb_out_d = BORDER_COLOR;
         end
`endif
      end
   end

   // One-cycle timing pipeline, composited colour and per-frame fill register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vcount_q     <= '0;
         hcount_q     <= '0;
         vsync_q      <= 1'b0;
         hsync_q      <= 1'b0;
         vblnk_q      <= 1'b0;
         hblnk_q      <= 1'b0;
         rgb_out_q    <= '0;
         fill_frame_q <= BAR_W;
      end else begin
         vcount_q     <= vcount_in;
         hcount_q     <= hcount_in;
         vsync_q      <= vsync_in;
         hsync_q      <= hsync_in;
         vblnk_q      <= vblnk_in;
         hblnk_q      <= hblnk_in;
         rgb_out_q    <= rgb_out_d;
         fill_frame_q <= fill_frame_d;
      end
   end

   assign vcount_out = vcount_q;
   assign hcount_out = hcount_q;
   assign vsync_out  = vsync_q;
   assign hsync_out  = hsync_q;
   assign vblnk_out  = vblnk_q;
   assign hblnk_out  = hblnk_q;
   assign rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_progress_bar_overlay.sv
// Directed self-checking bench for progress_bar_overlay with a 10 ms
// countdown and a 4-pixel bar; expected values are hand-computed.
module tb_progress_bar_overlay;
   import skyhop_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        module_en;
   logic        one_ms_tick;
   logic        start;
   logic        pause;
   logic [10:0] vcount_in, hcount_in;
   logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
   logic [11:0] rgb_in;
   logic [10:0] vcount_out, hcount_out;
   logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
   logic [11:0] rgb_out;
   logic        elapsed;
   logic [19:0] remaining_ms;

   int checks = 0;
   int errors = 0;
   int fillExp [10] = '{4, 4, 3, 3, 2, 2, 2, 1, 1, 0};

   progress_bar_overlay #(
      .BAR_X       (11'd16),
      .BAR_Y       (11'd8),
      .BAR_W       (11'd4),
      .BAR_H       (11'd12),
      .DURATION_MS (20'd10)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .module_en    (module_en),
      .one_ms_tick  (one_ms_tick),
      .start        (start),
      .pause        (pause),
      .vcount_in    (vcount_in),
      .hcount_in    (hcount_in),
      .vsync_in     (vsync_in),
      .hsync_in     (hsync_in),
      .vblnk_in     (vblnk_in),
      .hblnk_in     (hblnk_in),
      .rgb_in       (rgb_in),
      .vcount_out   (vcount_out),
      .hcount_out   (hcount_out),
      .vsync_out    (vsync_out),
      .hsync_out    (hsync_out),
      .vblnk_out    (vblnk_out),
      .hblnk_out    (hblnk_out),
      .rgb_out      (rgb_out),
      .elapsed      (elapsed),
      .remaining_ms (remaining_ms)
   );

   // 40 MHz pixel clock
   always #12.5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one pixel vector at a falling edge and wait until its output is registered.
   task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v, input logic hs, input logic vs,
                                input logic hb, input logic vb, input logic [11:0] rgb, input logic en);
      @(negedge clk);
      hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs;
      hblnk_in = hb; vblnk_in = vb; rgb_in = rgb; module_en = en;
      @(negedge clk);
   endtask

   task automatic doTick();
      @(negedge clk);
      one_ms_tick = 1'b1;
      @(negedge clk);
      one_ms_tick = 1'b0;
   endtask

   task automatic doStart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; module_en = 1'b1; one_ms_tick = 1'b0; start = 1'b0; pause = 1'b0;
      vcount_in = '0; hcount_in = '0; vsync_in = 1'b0; hsync_in = 1'b0;
      vblnk_in = 1'b0; hblnk_in = 1'b0; rgb_in = '0;
      #1;
      checkOutput("rst_remaining", remaining_ms, 10);
      checkOutput("rst_elapsed", elapsed, 0);
      checkOutput("rst_rgb", rgb_out, 12'h000);
      checkOutput("rst_vcount", vcount_out, 0);
      checkOutput("rst_hsync", hsync_out, 0);
      checkOutput("rst_state", dut.bar_state, IDLE);
      checkOutput("rst_fill", dut.fill, 4);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Full countdown: fill 4->3 at tick 3, 2 at 5, 1 at 8, 0 at 10
      $display("[TB] full countdown");
      doStart();
      checkOutput("start_state", dut.bar_state, RUN);
      for (int i = 1; i <= 10; i++) begin
         doTick();
         checkOutput($sformatf("fill_tick%0d", i), dut.fill, fillExp[i-1]);
         checkOutput($sformatf("remaining_tick%0d", i), remaining_ms, 10 - i);
         checkOutput($sformatf("elapsed_tick%0d", i), elapsed, (i == 10) ? 1 : 0);
      end
      doTick();
      checkOutput("elapsed_tick_ignored", remaining_ms, 0);
      @(negedge clk); pause = 1'b1;
      @(negedge clk); pause = 1'b0;
      checkOutput("elapsed_pause_ignored", dut.bar_state, ELAPSED);

      // Pause holds the countdown
      $display("[TB] pause");
      doStart();
      checkOutput("restart_remaining", remaining_ms, 10);
      checkOutput("restart_elapsed", elapsed, 0);
      for (int i = 0; i < 4; i++) doTick();
      checkOutput("pre_pause_remaining", remaining_ms, 6);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) doTick();
      checkOutput("pause_remaining", remaining_ms, 6);
      checkOutput("pause_state", dut.bar_state, PAUSE);
      pause = 1'b0;
      for (int i = 0; i < 5; i++) doTick();
      checkOutput("resume_remaining", remaining_ms, 1);
      checkOutput("resume_elapsed", elapsed, 0);
      doTick();
      checkOutput("final_remaining", remaining_ms, 0);
      checkOutput("final_elapsed", elapsed, 1);
      checkOutput("final_fill", dut.fill, 0);

      // Start edge coincident with tick 7: reload wins
      $display("[TB] start with tick");
      doStart();
      for (int i = 0; i < 6; i++) doTick();
      checkOutput("pre_reload_remaining", remaining_ms, 4);
      checkOutput("pre_reload_fill", dut.fill, 2);
      @(negedge clk); start = 1'b1; one_ms_tick = 1'b1;
      @(negedge clk); start = 1'b0; one_ms_tick = 1'b0;
      checkOutput("reload_remaining", remaining_ms, 10);
      checkOutput("reload_fill", dut.fill, 4);
      for (int i = 0; i < 3; i++) doTick();
      checkOutput("post_reload_remaining", remaining_ms, 7);
      checkOutput("post_reload_fill", dut.fill, 3);

      // Frame latch: fill=3 but fill_frame still 4 until vblnk rises
      $display("[TB] frame latch");
      applyStimulus(11'd19, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AA, 1'b1);
      checkOutput("midframe_old_fill", rgb_out, 12'hF80);
      applyStimulus(11'd0, 11'd600, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1);
      checkOutput("blank_forward", rgb_out, 12'h000);
      applyStimulus(11'd19, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AA, 1'b1);
      checkOutput("newframe_empty", rgb_out, 12'h333);
      applyStimulus(11'd18, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AA, 1'b1);
      checkOutput("newframe_fg", rgb_out, 12'hF80);
      applyStimulus(11'd20, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AA, 1'b1);
      checkOutput("right_edge_outside", rgb_out, 12'h0AA);
      applyStimulus(11'd15, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AB, 1'b1);
      checkOutput("left_edge_outside", rgb_out, 12'h0AB);
      applyStimulus(11'd16, 11'd19, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AC, 1'b1);
      checkOutput("bottom_row_inside", rgb_out, 12'hF80);
      applyStimulus(11'd16, 11'd20, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AD, 1'b1);
      checkOutput("below_outside", rgb_out, 12'h0AD);
      applyStimulus(11'd16, 11'd7, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AE, 1'b1);
      checkOutput("above_outside", rgb_out, 12'h0AE);
      applyStimulus(11'd16, 11'd8, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0AF, 1'b1);
      checkOutput("hblnk_forward", rgb_out, 12'h0AF);

      // module_en=0 passthrough and timing pipeline
      $display("[TB] passthrough");
      applyStimulus(11'd17, 11'd9, 1'b1, 1'b0, 1'b0, 1'b0, 12'hABC, 1'b0);
      checkOutput("disabled_rgb", rgb_out, 12'hABC);
      checkOutput("pipe_hcount", hcount_out, 17);
      checkOutput("pipe_vcount", vcount_out, 9);
      checkOutput("pipe_hsync", hsync_out, 1);
      checkOutput("pipe_vsync", vsync_out, 0);
      checkOutput("pipe_hblnk", hblnk_out, 0);
      applyStimulus(11'd1000, 11'd600, 1'b0, 1'b1, 1'b1, 1'b1, 12'h5A5, 1'b0);
      checkOutput("pipe_hcount2", hcount_out, 1000);
      checkOutput("pipe_vcount2", vcount_out, 600);
      checkOutput("pipe_hsync2", hsync_out, 0);
      checkOutput("pipe_vsync2", vsync_out, 1);
      checkOutput("pipe_vblnk2", vblnk_out, 1);
      checkOutput("pipe_hblnk2", hblnk_out, 1);
      checkOutput("pipe_rgb2", rgb_out, 12'h5A5);

      // Asynchronous reset mid-run
      $display("[TB] async reset");
      applyStimulus(11'd16, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
      for (int i = 0; i < 4; i++) doTick();
      checkOutput("prereset_remaining", remaining_ms, 3);
      checkOutput("prereset_rgb", rgb_out, 12'hF80);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_state", dut.bar_state, IDLE);
      checkOutput("async_remaining", remaining_ms, 10);
      checkOutput("async_elapsed", elapsed, 0);
      checkOutput("async_rgb", rgb_out, 12'h000);
      @(negedge clk); rst = 1'b0;
      applyStimulus(11'd16, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1);
      checkOutput("idle_passthrough", rgb_out, 12'h123);
      doTick();
      checkOutput("idle_tick_ignored", remaining_ms, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
